// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divider helper and parity function.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        e_reset,
        e_idle,
        e_start_bit,
        e_data_bits,
        e_parity_bit,
        e_stop_bit
    } uart_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Parity bit that makes the frame correct; data is zero-extended to 9 bits by the caller.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync_2ff #(
    parameter logic reset_val_p = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= reset_val_p;
            q_o    <= reset_val_p;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: samples each bit near its centre and presents words on a valid/yumi
// handshake with per-word parity and framing error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned clk_per_bit_p = baud_div(100_000_000, 9600),
    parameter int unsigned data_bits_p   = 8,
    parameter int unsigned parity_bit_p  = 0,
    parameter int unsigned parity_odd_p  = 0,
    parameter int unsigned stop_bits_p   = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   rx_i,
    output logic                   rx_v_o,
    output logic [data_bits_p-1:0] rx_o,
    input  logic                   rx_yumi_i,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   overrun_o
);

    localparam int unsigned CntW = $clog2(clk_per_bit_p + 1);
    localparam int unsigned BitW =
        $clog2((data_bits_p > stop_bits_p) ? data_bits_p : stop_bits_p);
    localparam logic [CntW-1:0] MidCnt   = CntW'((clk_per_bit_p - 1) / 2);
    localparam logic [CntW-1:0] EndCnt   = CntW'(clk_per_bit_p - 1);
    localparam logic [BitW-1:0] LastData = BitW'(data_bits_p - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(stop_bits_p - 1);

    logic rx_s;

    uart_sync_2ff #(
        .reset_val_p(1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    uart_state_e            state_q, state_d;
    logic [CntW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [data_bits_p-1:0] data_q, data_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   commit;
    logic [8:0]             data_ext;

    logic                   rx_v_q, rx_v_d;
    logic [data_bits_p-1:0] rx_q, rx_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    always_comb begin
        data_ext                   = '0;
        data_ext[data_bits_p-1:0] = data_q;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        commit    = 1'b0;

        unique case (state_q)
            e_idle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d   = e_start_bit;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            e_start_bit: begin
                if (clk_cnt_q == MidCnt) begin
                    clk_cnt_d = '0;
                    // A high line at mid-start is a glitch, not a frame.
                    state_d   = rx_s ? e_idle : e_data_bits;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            e_data_bits: begin
                if (clk_cnt_q == EndCnt) begin
                    clk_cnt_d         = '0;
                    data_d[bit_cnt_q] = rx_s;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        state_d   = (parity_bit_p != 0) ? e_parity_bit : e_stop_bit;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            e_parity_bit: begin
                if (clk_cnt_q == EndCnt) begin
                    clk_cnt_d = '0;
                    par_err_d = parity_calc(data_ext, parity_odd_p != 0) ^ rx_s;
                    state_d   = e_stop_bit;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            e_stop_bit: begin
                if (clk_cnt_q == EndCnt) begin
                    clk_cnt_d = '0;
                    frm_err_d = frm_err_q | ~rx_s;
                    if (bit_cnt_q == LastStop) begin
                        commit  = 1'b1;
                        state_d = e_idle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        rx_v_d       = rx_v_q;
        rx_d         = rx_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (commit) begin
            if (!rx_v_q || rx_yumi_i) begin
                rx_v_d       = 1'b1;
                rx_d         = data_q;
                parity_err_d = par_err_q;
                frame_err_d  = frm_err_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_yumi_i) begin
            rx_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= e_idle;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            rx_v_q       <= 1'b0;
            rx_q         <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            rx_v_q       <= rx_v_d;
            rx_q         <= rx_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_v_o       = rx_v_q;
    assign rx_o         = rx_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;

endmodule
